// File: rtl/mtx_ctrl_tag_chip.sv
// Frequency-hopped data tone plus a fixed pilot tone. Each frame is NSYMB symbols of
// NSIG samples: symbol 0 is pilot-only (SYNC) and the remaining symbols carry tx_bits (DATA).
module mtx_ctrl_tag_chip #(
    parameter int DATA_WIDTH   = 16,
    parameter int PHASE_WIDTH  = 24,
    parameter int NSYMB_WIDTH  = 16,
    parameter int NSIG         = 8192,
    parameter int PILOT_PH_INC = 4096,
    parameter int NSYMB        = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [11:0]               fp_gpio_in,
    input  logic [127:0]              tx_bits,
    output logic [DATA_WIDTH-1:0]     itx,
    output logic [DATA_WIDTH-1:0]     qtx,
    output logic                      hop_clk,
    output logic                      hop_rst,
    output logic [11:0]               fp_gpio_out,
    output logic [11:0]               fp_gpio_ddr,
    output logic [6:0]                ntx_bits_cnt,
    output logic [NSYMB_WIDTH-1:0]    symbN,
    output logic [PHASE_WIDTH-1:0]    sigN,
    output logic [PHASE_WIDTH-1:0]    count_sync,
    output logic [PHASE_WIDTH-1:0]    mtx_ph,
    output logic [PHASE_WIDTH-1:0]    pilot_ph,
    output logic [PHASE_WIDTH-1:0]    hop_ph_inc,
    output logic [6:0]                nhop,
    output logic [1:0]                mtx_state,
    output logic [2*DATA_WIDTH-1:0]   mtx_data,
    output logic [2*DATA_WIDTH-1:0]   pilot_data
);
    localparam int  LUT_BITS  = 10;
    localparam int  LUT_SIZE  = 1 << LUT_BITS;
    localparam int  FRAME_LEN = NSIG * NSYMB;
    localparam real TWO_PI    = 6.283185307179586;

    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2, HOLD = 2'd3} state_t;

    function automatic int round_amp(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    state_t state_q, state_d, saved_q, saved_d, run_next, st_p1_q;
    logic [PHASE_WIDTH-1:0] sig_q, sig_d, count_q, count_d;
    logic [PHASE_WIDTH-1:0] pilot_ph_q, pilot_ph_d, mtx_ph_q, mtx_ph_d, hop_inc;
    logic [NSYMB_WIDTH-1:0] symb_q, symb_d;
    logic [6:0]             nhop_q, nhop_d, ntx_q, ntx_d;
    logic [2*DATA_WIDTH-1:0] mtx_data_q, mtx_data_d, pilot_data_q, pilot_data_d;
    logic [DATA_WIDTH-1:0]  itx_q, itx_d, qtx_q, qtx_d;
    logic running, sig_wrap, last_symb, hold, cur_bit;
    logic [LUT_BITS-1:0] mtx_idx, pilot_idx;
    logic signed [DATA_WIDTH-1:0] pilot_cos, pilot_sin, mtx_cos, mtx_sin;
    logic unused_gpio;

    logic signed [DATA_WIDTH-1:0] cos_rom [LUT_SIZE];
    logic signed [DATA_WIDTH-1:0] sin_rom [LUT_SIZE];

    // Full-wave quadrature table, constant-folded at elaboration.
    for (genvar gi = 0; gi < LUT_SIZE; gi++) begin : g_rom
        localparam real ANG   = TWO_PI * real'(gi) / real'(LUT_SIZE);
        localparam int  COS_V = round_amp(32767.0 * $cos(ANG));
        localparam int  SIN_V = round_amp(32767.0 * $sin(ANG));
        assign cos_rom[gi] = DATA_WIDTH'(COS_V);
        assign sin_rom[gi] = DATA_WIDTH'(SIN_V);
    end

    assign hold        = fp_gpio_in[4];
    assign unused_gpio = ^{fp_gpio_in[11:5], fp_gpio_in[3:0]};
    assign running     = (state_q == SYNC) || (state_q == DATA);
    assign sig_wrap    = (sig_q == PHASE_WIDTH'(NSIG - 1));
    assign last_symb   = (symb_q == NSYMB_WIDTH'(NSYMB - 1));
    assign cur_bit     = tx_bits[ntx_q];
    assign hop_inc     = PHASE_WIDTH'(PILOT_PH_INC * (2 + int'(nhop_q[3:0])));
    assign mtx_idx     = mtx_ph_q[PHASE_WIDTH-1 -: LUT_BITS];
    assign pilot_idx   = pilot_ph_q[PHASE_WIDTH-1 -: LUT_BITS];

    // Where a running state goes after this clock, ignoring hold.
    always_comb begin
        run_next = state_q;
        if (sig_wrap) begin
            if (state_q == SYNC)
                run_next = DATA;
            else if (last_symb)
                run_next = SYNC;
        end
    end

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        case (state_q)
            IDLE: state_d = SYNC;
            SYNC, DATA: begin
                if (hold) begin
                    state_d = HOLD;
                    saved_d = run_next;
                end else begin
                    state_d = run_next;
                end
            end
            HOLD: if (!hold) state_d = saved_q;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sig_d      = sig_q;
        symb_d     = symb_q;
        count_d    = count_q;
        pilot_ph_d = pilot_ph_q;
        mtx_ph_d   = mtx_ph_q;
        nhop_d     = nhop_q;
        ntx_d      = ntx_q;
        if (running) begin
            pilot_ph_d = pilot_ph_q + PHASE_WIDTH'(PILOT_PH_INC);
            sig_d      = sig_wrap ? '0 : sig_q + PHASE_WIDTH'(1);
            count_d    = (count_q == PHASE_WIDTH'(FRAME_LEN - 1)) ? '0 : count_q + PHASE_WIDTH'(1);
            if (sig_wrap) begin
                symb_d = last_symb ? '0 : symb_q + NSYMB_WIDTH'(1);
                if (state_q == DATA) begin
                    nhop_d = nhop_q + 7'd1;
                    ntx_d  = ntx_q + 7'd1;
                end
            end
            // Data phase is continuous across DATA symbols and parked at 0 for SYNC.
            if ((state_q == DATA) && (run_next == DATA))
                mtx_ph_d = cur_bit ? (mtx_ph_q + hop_inc) : (mtx_ph_q - hop_inc);
            else
                mtx_ph_d = '0;
        end
    end

    always_comb begin
        mtx_data_d   = {cos_rom[mtx_idx], sin_rom[mtx_idx]};
        pilot_data_d = {cos_rom[pilot_idx], sin_rom[pilot_idx]};
        pilot_cos    = pilot_data_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
        pilot_sin    = pilot_data_q[DATA_WIDTH-1:0];
        mtx_cos      = mtx_data_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
        mtx_sin      = mtx_data_q[DATA_WIDTH-1:0];
        itx_d        = '0;
        qtx_d        = '0;
        // st_p1_q is the state that owned the phase now sitting in the table registers.
        case (st_p1_q)
            SYNC: begin
                itx_d = pilot_cos >>> 1;
                qtx_d = pilot_sin >>> 1;
            end
            DATA: begin
                itx_d = (pilot_cos >>> 1) + (mtx_cos >>> 1);
                qtx_d = (pilot_sin >>> 1) + (mtx_sin >>> 1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            saved_q      <= IDLE;
            st_p1_q      <= IDLE;
            sig_q        <= '0;
            symb_q       <= '0;
            count_q      <= '0;
            pilot_ph_q   <= '0;
            mtx_ph_q     <= '0;
            nhop_q       <= '0;
            ntx_q        <= '0;
            mtx_data_q   <= '0;
            pilot_data_q <= '0;
            itx_q        <= '0;
            qtx_q        <= '0;
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            st_p1_q      <= state_q;
            sig_q        <= sig_d;
            symb_q       <= symb_d;
            count_q      <= count_d;
            pilot_ph_q   <= pilot_ph_d;
            mtx_ph_q     <= mtx_ph_d;
            nhop_q       <= nhop_d;
            ntx_q        <= ntx_d;
            mtx_data_q   <= mtx_data_d;
            pilot_data_q <= pilot_data_d;
            itx_q        <= itx_d;
            qtx_q        <= qtx_d;
        end
    end

    assign hop_clk      = running && (sig_q == '0);
    assign hop_rst      = running && (count_q == '0);
    assign itx          = itx_q;
    assign qtx          = qtx_q;
    assign fp_gpio_ddr  = 12'h00F;
    assign fp_gpio_out  = {8'h00, (state_q == DATA), cur_bit, hop_rst, hop_clk};
    assign ntx_bits_cnt = ntx_q;
    assign symbN        = symb_q;
    assign sigN         = sig_q;
    assign count_sync   = count_q;
    assign mtx_ph       = mtx_ph_q;
    assign pilot_ph     = pilot_ph_q;
    assign hop_ph_inc   = hop_inc;
    assign nhop         = nhop_q;
    assign mtx_state    = state_q;
    assign mtx_data     = mtx_data_q;
    assign pilot_data   = pilot_data_q;

endmodule

// File: tb/tb_mtx_ctrl_tag_chip.sv
// Bench for mtx_ctrl_tag_chip: random holds and tx_bits checked every cycle against a
// frame-position reference model, plus targeted checks at symbol and frame boundaries.
`timescale 1ns/1ps
module tb_mtx_ctrl_tag_chip;
    localparam int PW    = 24;
    localparam int NSIG  = 8192;
    localparam int PINC  = 4096;
    localparam int NSYMB = 9;
    localparam int FRAME = NSIG * NSYMB;
    localparam int PMASK = (1 << PW) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [11:0]  fp_gpio_in;
    logic [127:0] tx_bits;
    logic [15:0]  itx, qtx;
    logic         hop_clk, hop_rst;
    logic [11:0]  fp_gpio_out, fp_gpio_ddr;
    logic [6:0]   ntx_bits_cnt, nhop;
    logic [15:0]  symbN;
    logic [23:0]  sigN, count_sync, mtx_ph, pilot_ph, hop_ph_inc;
    logic [1:0]   mtx_state;
    logic [31:0]  mtx_data, pilot_data;

    mtx_ctrl_tag_chip dut (
        .clk(clk), .reset(reset), .fp_gpio_in(fp_gpio_in), .tx_bits(tx_bits),
        .itx(itx), .qtx(qtx), .hop_clk(hop_clk), .hop_rst(hop_rst),
        .fp_gpio_out(fp_gpio_out), .fp_gpio_ddr(fp_gpio_ddr),
        .ntx_bits_cnt(ntx_bits_cnt), .symbN(symbN), .sigN(sigN),
        .count_sync(count_sync), .mtx_ph(mtx_ph), .pilot_ph(pilot_ph),
        .hop_ph_inc(hop_ph_inc), .nhop(nhop), .mtx_state(mtx_state),
        .mtx_data(mtx_data), .pilot_data(pilot_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit abort_run = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
            if (failures >= 40) abort_run = 1'b1;
        end
    endtask

    // Reference model: mode 0=idle 1=running 3=held; everything else follows from frame position.
    int tab_cos [1024];
    int tab_sin [1024];
    int m_mode, m_pos, m_pilot, m_mtx, m_nhop, m_ntx, frame_wraps;
    int e_mtx_cos, e_mtx_sin, e_pil_cos, e_pil_sin, e_itx, e_qtx, e_gate;

    function automatic int round_amp(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic int exp_state();
        if (m_mode == 0) return 0;
        if (m_mode == 3) return 3;
        return (m_pos / NSIG == 0) ? 1 : 2;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_pilot = 0; m_mtx = 0; m_nhop = 0; m_ntx = 0;
        e_mtx_cos = 0; e_mtx_sin = 0; e_pil_cos = 0; e_pil_sin = 0;
        e_itx = 0; e_qtx = 0; e_gate = 0; frame_wraps = 0;
    endtask

    task automatic model_clock(input bit h);
        int  st, inc;
        bit  was_data;
        st = exp_state();
        e_itx = 0;
        e_qtx = 0;
        if (e_gate == 1) begin
            e_itx = e_pil_cos >>> 1;
            e_qtx = e_pil_sin >>> 1;
        end else if (e_gate == 2) begin
            e_itx = (e_pil_cos >>> 1) + (e_mtx_cos >>> 1);
            e_qtx = (e_pil_sin >>> 1) + (e_mtx_sin >>> 1);
        end
        e_mtx_cos = tab_cos[m_mtx >> (PW - 10)];
        e_mtx_sin = tab_sin[m_mtx >> (PW - 10)];
        e_pil_cos = tab_cos[m_pilot >> (PW - 10)];
        e_pil_sin = tab_sin[m_pilot >> (PW - 10)];
        e_gate = st;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            was_data = (m_pos / NSIG) != 0;
            if (was_data) begin
                inc = PINC * (2 + (m_nhop % 16));
                m_mtx = tx_bits[m_ntx] ? ((m_mtx + inc) & PMASK) : ((m_mtx - inc) & PMASK);
            end
            m_pilot = (m_pilot + PINC) & PMASK;
            m_pos = (m_pos + 1) % FRAME;
            if (m_pos % NSIG == 0) begin
                if (was_data) begin
                    m_nhop = (m_nhop + 1) % 128;
                    m_ntx  = (m_ntx + 1) % 128;
                end
                if (m_pos == 0) frame_wraps++;
            end
            if (m_pos / NSIG == 0) m_mtx = 0;
            if (h) m_mode = 3;
        end else if (!h) begin
            m_mode = 1;
        end
    endtask

    task automatic compare_all();
        int st;
        bit e_hclk, e_hrst;
        logic [31:0] v;
        st = exp_state();
        e_hclk = (m_mode == 1) && (m_pos % NSIG == 0);
        e_hrst = (m_mode == 1) && (m_pos == 0);
        check_eq("state", mtx_state, st);
        check_eq("sigN", sigN, m_pos % NSIG);
        check_eq("symbN", symbN, m_pos / NSIG);
        check_eq("count_sync", count_sync, m_pos);
        check_eq("pilot_ph", pilot_ph, m_pilot);
        check_eq("mtx_ph", mtx_ph, m_mtx);
        check_eq("hop_ph_inc", hop_ph_inc, PINC * (2 + (m_nhop % 16)));
        check_eq("nhop", nhop, m_nhop);
        check_eq("ntx_bits_cnt", ntx_bits_cnt, m_ntx);
        check_eq("hop_clk", hop_clk, e_hclk);
        check_eq("hop_rst", hop_rst, e_hrst);
        v = {16'(e_mtx_cos), 16'(e_mtx_sin)};
        check_eq("mtx_data", mtx_data, v);
        v = {16'(e_pil_cos), 16'(e_pil_sin)};
        check_eq("pilot_data", pilot_data, v);
        check_eq("itx", itx, e_itx & 'hFFFF);
        check_eq("qtx", qtx, e_qtx & 'hFFFF);
        check_eq("fp_gpio_out", fp_gpio_out, {8'h00, (st == 2), tx_bits[m_ntx], e_hrst, e_hclk});
        check_eq("fp_gpio_ddr", fp_gpio_ddr, 12'h00F);
    endtask

    // Drive inputs at a falling edge, advance the model across the rising edge, then compare.
    task automatic step(input bit h, input logic [11:0] other);
        fp_gpio_in = {other[11:5], h, other[3:0]};
        model_clock(h);
        @(negedge clk);
        compare_all();
    endtask

    int  hold_left;
    bit  h, reached, done, forced_done;
    bit  ev_rel, ev_rel1, ev_s1, ev_s1d, ev_s2, ev_s2i, ev_wrap, ev_hold;
    int  post;

    initial begin
        for (int k = 0; k < 1024; k++) begin
            tab_cos[k] = round_amp(32767.0 * $cos(6.283185307179586 * real'(k) / 1024.0));
            tab_sin[k] = round_amp(32767.0 * $sin(6.283185307179586 * real'(k) / 1024.0));
        end
        reset = 1'b0;
        fp_gpio_in = '0;
        tx_bits = '0;
        model_reset();
        #3;
        $display("reset check at time 0");
        compare_all();
        repeat (3) begin
            @(negedge clk);
            compare_all();
        end

        // Random tx_bits and random holds, run into the first DATA symbol, then reset asynchronously.
        tx_bits = {$urandom, $urandom, $urandom, $urandom};
        reset = 1'b1;
        $display("phase A release tx_bits=%032h", tx_bits);
        hold_left = 0;
        reached = 1'b0;
        for (int cyc = 0; cyc < 12000 && !abort_run; cyc++) begin
            if (m_mode == 1 && m_pos >= 10000) begin
                reached = 1'b1;
                break;
            end
            if (hold_left > 0) begin
                h = 1'b1;
                hold_left--;
            end else begin
                h = 1'b0;
                if ($urandom_range(0, 999) == 0) hold_left = $urandom_range(1, 30);
            end
            step(h, 12'($urandom));
        end
        if (!abort_run) check_eq("phaseA_reached_data", reached, 1'b1);

        if (!abort_run) begin
            #1 reset = 1'b0;
            #1;
            model_reset();
            $display("mid-frame async reset at %0t", $time);
            compare_all();
            @(negedge clk);
            compare_all();
        end

        // Fixed pattern over a full frame, with one long hold mid-DATA and random short holds.
        fp_gpio_in = '0;
        tx_bits = {48'h0, 80'h0AAAAAAAAAAAAAAAAAAA};
        reset = 1'b1;
        $display("phase B release tx_bits=%032h", tx_bits);
        hold_left = 0;
        done = 1'b0;
        forced_done = 1'b0;
        post = 0;
        {ev_rel, ev_rel1, ev_s1, ev_s1d, ev_s2, ev_s2i, ev_wrap, ev_hold} = '0;
        for (int cyc = 0; cyc < 78000 && !abort_run && !done; cyc++) begin
            if (!forced_done && m_mode == 1 && m_pos == 20000 && hold_left == 0) begin
                forced_done = 1'b1;
                hold_left = 100;
                $display("forced hold of 100 clocks at count_sync=%0d", m_pos);
            end
            if (hold_left > 0) begin
                h = 1'b1;
                hold_left--;
            end else begin
                h = 1'b0;
                if (m_pos > 2 * NSIG + 2 && $urandom_range(0, 1999) == 0)
                    hold_left = $urandom_range(1, 30);
            end
            step(h, 12'h000);

            if (!ev_rel && exp_state() == 1 && m_pos == 0) begin
                ev_rel = 1'b1;
                check_eq("rel_state", mtx_state, 2'd1);
                check_eq("rel_hop_clk", hop_clk, 1'b1);
                check_eq("rel_hop_rst", hop_rst, 1'b1);
            end
            if (!ev_rel1 && exp_state() == 1 && m_pos == 1) begin
                ev_rel1 = 1'b1;
                check_eq("rel_pilot_step", pilot_ph, 24'd4096);
                check_eq("rel_mtx_zero", mtx_ph, 24'd0);
            end
            if (!ev_s1 && exp_state() == 2 && m_pos == NSIG) begin
                ev_s1 = 1'b1;
                check_eq("sym1_symbN", symbN, 16'd1);
                check_eq("sym1_state", mtx_state, 2'd2);
                check_eq("sym1_inc", hop_ph_inc, 24'd8192);
            end
            if (!ev_s1d && exp_state() == 2 && m_pos == NSIG + 1) begin
                ev_s1d = 1'b1;
                check_eq("sym1_decrement", mtx_ph, 24'hFFE000);
            end
            if (!ev_s2 && exp_state() == 2 && m_pos == 2 * NSIG) begin
                ev_s2 = 1'b1;
                check_eq("sym2_ntx", ntx_bits_cnt, 7'd1);
                check_eq("sym2_nhop", nhop, 7'd1);
                check_eq("sym2_inc", hop_ph_inc, 24'd12288);
            end
            if (!ev_s2i && exp_state() == 2 && m_pos == 2 * NSIG + 1) begin
                ev_s2i = 1'b1;
                check_eq("sym2_increment", mtx_ph, 24'd12288);
            end
            if (!ev_hold && forced_done && hold_left == 50) begin
                ev_hold = 1'b1;
                $display("mid-hold check at count_sync=%0d", m_pos);
                check_eq("hold_state", mtx_state, 2'd3);
                check_eq("hold_itx", itx, 16'd0);
                check_eq("hold_qtx", qtx, 16'd0);
            end
            if (!ev_wrap && frame_wraps == 1 && exp_state() == 1 && m_pos == 0) begin
                ev_wrap = 1'b1;
                $display("frame wrap observed at %0t", $time);
                check_eq("wrap_ntx", ntx_bits_cnt, 7'd8);
                check_eq("wrap_state", mtx_state, 2'd1);
                check_eq("wrap_hop_rst", hop_rst, 1'b1);
                check_eq("wrap_symbN", symbN, 16'd0);
            end
            if (ev_wrap) begin
                post++;
                if (post >= 300) done = 1'b1;
            end
        end
        if (!abort_run) check_eq("phaseB_frame_wrap", done, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
